csr_access_seq: RTL and testbench
=================================

Name: csr_access_seq

Overview:
- Initiator side of the CSR register file port: the only block that drives its read address, write address, write value and write enable.
- Sequences Zicsr read-modify-write instructions, M-mode trap entry and MRET as multi-cycle CSR transactions.
- Returns rd data and PC redirects to the core.
- The register file has one write port and forwards a same-address write into the read value within the same cycle. This block therefore never reads and writes the same CSR in one cycle.

Parameters:
- MSTATUS_ADDR, 12'h300, mstatus address
- MTVEC_ADDR, 12'h305, mtvec address
- MEPC_ADDR, 12'h341, mepc address
- MCAUSE_ADDR, 12'h342, mcause address

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  CSR instruction request
- req_ready  out  1  high only in IDLE
- req_funct3  in  3  Zicsr funct3
- req_addr  in  12  CSR address
- req_src  in  32  rs1 value, or zimm zero-extended to 32 bits
- req_src_zero  in  1  rs1/zimm field is 0 (suppresses the write for S/C ops)
- trap_valid  in  1  trap request
- trap_cause  in  32  mcause value
- trap_pc  in  32  faulting PC
- mret_valid  in  1  MRET request
- csr_r_addr  out  12  to register file
- csr_r_val  in  32  from register file (combinational)
- csr_w_addr  out  12  to register file
- csr_w_val  out  32  to register file
- w_enable  out  1  to register file
- done  out  1  1-cycle pulse: CSR op complete
- rd_val  out  32  old CSR value, valid with done
- illegal  out  1  1-cycle pulse: bad funct3
- redirect_valid  out  1  1-cycle pulse
- redirect_pc  out  32  valid with redirect_valid

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; req_ready=1.
  - w_enable, done, illegal, redirect_valid = 0.
  - rd_val, redirect_pc, csr_w_val, csr_w_addr, csr_r_addr = 0.
- Accept:
  - Evaluated in IDLE only.
  - Priority when simultaneous: trap_valid > mret_valid > req_valid.
  - All request fields are registered at accept; inputs are ignored outside IDLE.
- States: IDLE, CSR_RD, CSR_WR, T_EPC, T_CAUSE, T_ST_RD, T_ST_WR, T_VEC, M_ST_RD, M_ST_WR, M_EPC.
- CSR ops:
  - funct3 001/101 → RW; 010/110 → RS; 011/111 → RC.
  - funct3 000/100 → illegal pulse 1 cycle after accept, no CSR access, back to IDLE.
  - CSR_RD: csr_r_addr=addr; latch old=csr_r_val; w_enable=0.
  - CSR_WR: new value = RW: src; RS: old|src; RC: old&~src.
  - w_enable=1 unless (RS or RC) and src_zero.
  - done=1 and rd_val=old, registered so they are visible in the cycle after CSR_WR.
  - Latency: accept at cycle N → write in N+2 → done observed in N+3. Then IDLE.
- Trap entry, one CSR write per state:
  - T_EPC: mepc = {trap_pc[31:2],2'b00}.
  - T_CAUSE: mcause = trap_cause.
  - T_ST_RD: read mstatus, latch.
  - T_ST_WR: write mstatus with MPIE(bit7)=old MIE(bit3), MIE=0, MPP[12:11]=2'b11, other bits unchanged.
  - T_VEC: read mtvec; redirect_pc = {mtvec[31:2],2'b00}, except vectored mode (see Optional Feature).
  - redirect_valid pulses 1 cycle after T_VEC; then IDLE.
- MRET:
  - M_ST_RD: read mstatus.
  - M_ST_WR: write mstatus with MIE=old MPIE, MPIE=1, MPP=2'b11 (M-only hart).
  - M_EPC: read mepc; redirect_pc = mepc with bits[1:0] forced to 0; redirect_valid pulses; IDLE.
- Outputs and addressing:
  - w_enable is asserted only in *_WR, T_EPC and T_CAUSE states, with csr_w_addr equal to the target CSR.
  - csr_r_addr is never equal to csr_w_addr while w_enable=1.
- Arithmetic:
  - Vector offset is cause[30:0]<<2, truncated to 32 bits.
  - Addition wraps modulo 2^32.
- Reset mid-sequence: abort immediately to IDLE. A partially written trap sequence is not resumed; no done or redirect pulse is produced.

Optional Feature:
- Macro: CSR_VECTORED_EN.
- Defined: when mtvec[1:0]==2'b01 and mcause[31]==1 (interrupt), redirect_pc = {mtvec[31:2],2'b00} + (trap_cause[30:0]<<2).
- Undefined: mtvec[1:0] is ignored; redirect_pc is always the base.
- Exceptions (mcause[31]=0) always go to the base, with or without the macro.

Test Plan:
- CSRRW mscratch(0x340)=0x11 with register file holding 0x55 → w_enable one cycle, mscratch=0x11; done at N+3 with rd_val=0x55.
- CSRRS mstatus, src=0x8, src_zero=0, old=0xdeadbeef → writes 0xdeadbeef (bit3 already set); rd_val=0xdeadbeef. Repeat with src_zero=1 → w_enable never asserts.
- CSRRC 0x300, src=0x8, old=0x0000_0088 → writes 0x0000_0080. Then funct3=100 → illegal pulse, w_enable stays 0.
- Trap, pc=0x1002, cause=0xB, mstatus=0x8, mtvec=0x8000_0000 → mepc=0x1000, mcause=0xB, mstatus=0x1880, redirect_pc=0x8000_0000.
- CSR_VECTORED_EN, cause=0x8000_0007, mtvec=0x8000_0001 → redirect_pc=0x8000_001C. Without the macro → 0x8000_0000. Then MRET with mstatus=0x1880, mepc=0x1000 → mstatus=0x1888, redirect_pc=0x1000.
- trap_valid, mret_valid and req_valid all high together → trap sequence only. Assert reset during T_ST_RD → outputs return to reset values, no redirect pulse, req_ready=1.

Source files
------------

// File: rtl/csr_access_seq.sv
// Initiator for the CSR register file port: sequences Zicsr ops, M-mode trap entry and MRET.
// Optional `CSR_VECTORED_EN enables vectored mtvec dispatch for interrupts.
module csr_access_seq #(
    parameter logic [11:0] MSTATUS_ADDR = 12'h300,
    parameter logic [11:0] MTVEC_ADDR   = 12'h305,
    parameter logic [11:0] MEPC_ADDR    = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR  = 12'h342
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_src,
    input  logic        req_src_zero,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        mret_valid,
    output logic [11:0] csr_r_addr,
    input  logic [31:0] csr_r_val,
    output logic [11:0] csr_w_addr,
    output logic [31:0] csr_w_val,
    output logic        w_enable,
    output logic        done,
    output logic [31:0] rd_val,
    output logic        illegal,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [3:0] {
        IDLE, CSR_RD, CSR_WR,
        T_EPC, T_CAUSE, T_ST_RD, T_ST_WR, T_VEC,
        M_ST_RD, M_ST_WR, M_EPC
    } state_t;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;

    state_t      state_q, state_d;
    logic [11:0] addr_q;
    logic [31:0] src_q;
    logic        src_zero_q;
    logic [1:0]  op_q;
    logic [29:0] epc_q;
    logic [31:0] cause_q;
    logic [31:0] old_q, old_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;
    logic        redir_v_q, redir_v_d;
    logic [31:0] rd_val_q, rd_val_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        accept;
    logic [31:0] vec_base;

    // funct3[2] only selects the immediate form, already folded into req_src
    logic unused_funct3;
    assign unused_funct3 = req_funct3[2];

    function automatic logic [31:0] csr_op_result(input logic [1:0] op,
                                                   input logic [31:0] old,
                                                   input logic [31:0] src);
        case (op)
            OP_RW:   csr_op_result = src;
            OP_RS:   csr_op_result = old | src;
            default: csr_op_result = old & ~src;
        endcase
    endfunction

    function automatic logic [31:0] mstatus_trap(input logic [31:0] old);
        mstatus_trap        = old;
        mstatus_trap[7]     = old[3];
        mstatus_trap[3]     = 1'b0;
        mstatus_trap[12:11] = 2'b11;
    endfunction

    function automatic logic [31:0] mstatus_mret(input logic [31:0] old);
        mstatus_mret        = old;
        mstatus_mret[3]     = old[7];
        mstatus_mret[7]     = 1'b1;
        mstatus_mret[12:11] = 2'b11;
    endfunction

    assign accept   = (state_q == IDLE) && (trap_valid || mret_valid || req_valid);
    assign vec_base = {csr_r_val[31:2], 2'b00};

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        csr_r_addr = '0;
        csr_w_addr = '0;
        csr_w_val  = '0;
        w_enable   = 1'b0;
        old_d      = old_q;
        done_d     = 1'b0;
        illegal_d  = 1'b0;
        redir_v_d  = 1'b0;
        rd_val_d   = rd_val_q;
        redir_pc_d = redir_pc_q;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (trap_valid)      state_d = T_EPC;
                else if (mret_valid) state_d = M_ST_RD;
                else if (req_valid) begin
                    if (req_funct3[1:0] == 2'b00) illegal_d = 1'b1;
                    else                          state_d   = CSR_RD;
                end
            end
            CSR_RD: begin
                csr_r_addr = addr_q;
                old_d      = csr_r_val;
                state_d    = CSR_WR;
            end
            CSR_WR: begin
                // Read port parked on a different address so it never aliases the write
                csr_r_addr = ~addr_q;
                csr_w_addr = addr_q;
                csr_w_val  = csr_op_result(op_q, old_q, src_q);
                w_enable   = !((op_q != OP_RW) && src_zero_q);
                done_d     = 1'b1;
                rd_val_d   = old_q;
                state_d    = IDLE;
            end
            T_EPC: begin
                csr_w_addr = MEPC_ADDR;
                csr_w_val  = {epc_q, 2'b00};
                w_enable   = 1'b1;
                state_d    = T_CAUSE;
            end
            T_CAUSE: begin
                csr_w_addr = MCAUSE_ADDR;
                csr_w_val  = cause_q;
                w_enable   = 1'b1;
                state_d    = T_ST_RD;
            end
            T_ST_RD: begin
                csr_r_addr = MSTATUS_ADDR;
                old_d      = csr_r_val;
                state_d    = T_ST_WR;
            end
            T_ST_WR: begin
                csr_w_addr = MSTATUS_ADDR;
                csr_w_val  = mstatus_trap(old_q);
                w_enable   = 1'b1;
                state_d    = T_VEC;
            end
            T_VEC: begin
                csr_r_addr = MTVEC_ADDR;
`ifdef CSR_VECTORED_EN
                if (csr_r_val[1:0] == 2'b01 && cause_q[31])
                    redir_pc_d = vec_base + {cause_q[29:0], 2'b00};
                else
                    redir_pc_d = vec_base;
`else
                redir_pc_d = vec_base;
`endif
                redir_v_d  = 1'b1;
                state_d    = IDLE;
            end
            M_ST_RD: begin
                csr_r_addr = MSTATUS_ADDR;
                old_d      = csr_r_val;
                state_d    = M_ST_WR;
            end
            M_ST_WR: begin
                csr_w_addr = MSTATUS_ADDR;
                csr_w_val  = mstatus_mret(old_q);
                w_enable   = 1'b1;
                state_d    = M_EPC;
            end
            M_EPC: begin
                csr_r_addr = MEPC_ADDR;
                redir_pc_d = {csr_r_val[31:2], 2'b00};
                redir_v_d  = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
            redir_v_q  <= 1'b0;
            rd_val_q   <= '0;
            redir_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            illegal_q  <= illegal_d;
            redir_v_q  <= redir_v_d;
            rd_val_q   <= rd_val_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    // Request fields and the latched old value are pure data; no reset needed
    always_ff @(posedge clock) begin
        old_q <= old_d;
        if (accept) begin
            addr_q     <= req_addr;
            src_q      <= req_src;
            src_zero_q <= req_src_zero;
            op_q       <= req_funct3[1:0];
            epc_q      <= trap_pc[31:2];
            cause_q    <= trap_cause;
        end
    end

    assign done           = done_q;
    assign illegal        = illegal_q;
    assign redirect_valid = redir_v_q;
    assign rd_val         = rd_val_q;
    assign redirect_pc    = redir_pc_q;

endmodule

// File: tb/tb_csr_access_seq.sv
// Directed bench for csr_access_seq with a behavioural CSR register file (same-cycle write forwarding).
module tb_csr_access_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_src_zero = 1'b0, trap_valid = 1'b0, mret_valid = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_src = '0, trap_cause = '0, trap_pc = '0;
    logic        req_ready, w_enable, done, illegal, redirect_valid;
    logic [11:0] csr_r_addr, csr_w_addr;
    logic [31:0] csr_r_val, csr_w_val, rd_val, redirect_pc;

    logic [31:0] rf [4096];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [31:0] pl_data = '0;

    int checks = 0, errors = 0;
    int wen_cnt = 0, done_cnt = 0, redir_cnt = 0, ill_cnt = 0, coll_cnt = 0;

    csr_access_seq dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_src(req_src), .req_src_zero(req_src_zero),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .mret_valid(mret_valid),
        .csr_r_addr(csr_r_addr), .csr_r_val(csr_r_val),
        .csr_w_addr(csr_w_addr), .csr_w_val(csr_w_val), .w_enable(w_enable),
        .done(done), .rd_val(rd_val), .illegal(illegal),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clock = ~clock;

    assign csr_r_val = (w_enable && csr_w_addr == csr_r_addr) ? csr_w_val : rf[csr_r_addr];

    always @(posedge clock) begin
        if (w_enable)   rf[csr_w_addr] <= csr_w_val;
        else if (pl_en) rf[pl_addr]    <= pl_data;
        if (w_enable) wen_cnt <= wen_cnt + 1;
        if (w_enable && csr_r_addr == csr_w_addr) coll_cnt <= coll_cnt + 1;
        if (done)           done_cnt  <= done_cnt + 1;
        if (redirect_valid) redir_cnt <= redir_cnt + 1;
        if (illegal)        ill_cnt   <= ill_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic csr_op(input string tag, input logic [2:0] f3, input logic [11:0] a,
                          input logic [31:0] s, input logic sz, input logic exp_we,
                          input logic [31:0] exp_w, input logic [31:0] exp_old);
        int w0;
        w0 = wen_cnt;
        req_funct3 = f3; req_addr = a; req_src = s; req_src_zero = sz; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check({tag, "_rd_addr"}, {20'd0, csr_r_addr}, {20'd0, a});
        check({tag, "_rd_we"}, {31'd0, w_enable}, 32'd0);
        tick();
        check({tag, "_wr_we"}, {31'd0, w_enable}, {31'd0, exp_we});
        check({tag, "_wr_addr"}, {20'd0, csr_w_addr}, {20'd0, a});
        check({tag, "_wr_val"}, csr_w_val, exp_w);
        check({tag, "_done_early"}, {31'd0, done}, 32'd0);
        tick();
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_rd_val"}, rd_val, exp_old);
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_wen_cnt"}, wen_cnt - w0, {31'd0, exp_we});
        tick();
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    // Returns the number of cycles after the accept cycle until redirect_valid is seen
    task automatic wait_redirect(output int cyc);
        cyc = 0;
        while (!redirect_valid && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic do_trap(input logic [31:0] pc, input logic [31:0] cause, output int cyc);
        trap_pc = pc; trap_cause = cause; trap_valid = 1'b1;
        tick();
        trap_valid = 1'b0;
        wait_redirect(cyc);
    endtask

    initial begin
        int cyc, d0, r0, w0;
        logic [31:0] exp_vec;

        // Reset state
        tick();
        tick();
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_we", {31'd0, w_enable}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_redir", {31'd0, redirect_valid}, 32'd0);
        check("rst_rd_val", rd_val, 32'd0);
        check("rst_redir_pc", redirect_pc, 32'd0);
        check("rst_w_val", csr_w_val, 32'd0);
        check("rst_w_addr", {20'd0, csr_w_addr}, 32'd0);
        check("rst_r_addr", {20'd0, csr_r_addr}, 32'd0);
        reset = 1'b1;
        tick();

        // Zicsr read-modify-write ops
        preload(12'h340, 32'h55);
        csr_op("rw", 3'b001, 12'h340, 32'h11, 1'b0, 1'b1, 32'h11, 32'h55);
        check("rw_rf", rf[12'h340], 32'h11);
        preload(12'h300, 32'hdeadbeef);
        csr_op("rs", 3'b010, 12'h300, 32'h8, 1'b0, 1'b1, 32'hdeadbeef, 32'hdeadbeef);
        check("rs_rf", rf[12'h300], 32'hdeadbeef);
        preload(12'h300, 32'h0000_00f0);
        csr_op("rs_z", 3'b110, 12'h300, 32'h0, 1'b1, 1'b0, 32'h0000_00f0, 32'h0000_00f0);
        check("rs_z_rf", rf[12'h300], 32'h0000_00f0);
        preload(12'h300, 32'h0000_0088);
        csr_op("rc", 3'b011, 12'h300, 32'h8, 1'b0, 1'b1, 32'h0000_0080, 32'h0000_0088);
        check("rc_rf", rf[12'h300], 32'h0000_0080);

        // Illegal funct3
        w0 = wen_cnt; d0 = done_cnt;
        req_funct3 = 3'b100; req_addr = 12'h300; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("ill_pulse", {31'd0, illegal}, 32'd1);
        check("ill_we", {31'd0, w_enable}, 32'd0);
        tick();
        check("ill_pulse_end", {31'd0, illegal}, 32'd0);
        tick();
        check("ill_wen_cnt", wen_cnt - w0, 32'd0);
        check("ill_done_cnt", done_cnt - d0, 32'd0);
        check("ill_cnt", ill_cnt, 32'd1);

        // Trap entry, exception
        preload(12'h300, 32'h8);
        preload(12'h305, 32'h8000_0000);
        w0 = wen_cnt;
        do_trap(32'h1002, 32'hB, cyc);
        check("trap_latency", cyc, 32'd5);
        check("trap_redir_pc", redirect_pc, 32'h8000_0000);
        check("trap_mepc", rf[12'h341], 32'h1000);
        check("trap_mcause", rf[12'h342], 32'hB);
        check("trap_mstatus", rf[12'h300], 32'h1880);
        check("trap_wen_cnt", wen_cnt - w0, 32'd3);
        tick();
        check("trap_redir_pulse", {31'd0, redirect_valid}, 32'd0);
        check("trap_ready", {31'd0, req_ready}, 32'd1);

        // Interrupt with vectored mtvec
        preload(12'h305, 32'h8000_0001);
`ifdef CSR_VECTORED_EN
        exp_vec = 32'h8000_001C;
`else
        exp_vec = 32'h8000_0000;
`endif
        do_trap(32'h2000, 32'h8000_0007, cyc);
        check("vec_redir_pc", redirect_pc, exp_vec);
        check("vec_mcause", rf[12'h342], 32'h8000_0007);
        tick();

        // MRET
        preload(12'h300, 32'h1880);
        preload(12'h341, 32'h1000);
        mret_valid = 1'b1;
        tick();
        mret_valid = 1'b0;
        wait_redirect(cyc);
        check("mret_latency", cyc, 32'd3);
        check("mret_redir_pc", redirect_pc, 32'h1000);
        check("mret_mstatus", rf[12'h300], 32'h1888);
        tick();

        // Simultaneous requests: trap wins
        preload(12'h340, 32'h77);
        d0 = done_cnt; r0 = redir_cnt;
        req_funct3 = 3'b001; req_addr = 12'h340; req_src = 32'hAA; req_valid = 1'b1;
        mret_valid = 1'b1;
        do_trap(32'h3006, 32'h2, cyc);
        req_valid = 1'b0; mret_valid = 1'b0;
        check("prio_latency", cyc, 32'd5);
        check("prio_redir_pc", redirect_pc, 32'h8000_0000);
        check("prio_mcause", rf[12'h342], 32'h2);
        check("prio_mepc", rf[12'h341], 32'h3004);
        tick();
        tick();
        check("prio_mscratch", rf[12'h340], 32'h77);
        check("prio_done_cnt", done_cnt - d0, 32'd0);
        check("prio_redir_cnt", redir_cnt - r0, 32'd1);

        // Reset during T_ST_RD
        preload(12'h300, 32'h8);
        d0 = done_cnt; r0 = redir_cnt;
        trap_pc = 32'h4000; trap_cause = 32'h5; trap_valid = 1'b1;
        tick();
        trap_valid = 1'b0;
        tick();
        tick();
        check("mid_in_st_rd", {20'd0, csr_r_addr}, 32'h300);
        reset = 1'b0;
        #1;
        check("mid_ready", {31'd0, req_ready}, 32'd1);
        check("mid_we", {31'd0, w_enable}, 32'd0);
        check("mid_r_addr", {20'd0, csr_r_addr}, 32'd0);
        check("mid_redir_pc", redirect_pc, 32'd0);
        check("mid_rd_val", rd_val, 32'd0);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("mid_redir_cnt", redir_cnt - r0, 32'd0);
        check("mid_done_cnt", done_cnt - d0, 32'd0);
        check("mid_mstatus", rf[12'h300], 32'h8);
        check("mid_idle", {31'd0, req_ready}, 32'd1);

        check("rw_collisions", coll_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
